shift_arbiter: RTL and testbench
================================

# shift_arbiter

Sequencer and arbiter for the single shared barrel shifter in the add/subtract datapath. Two requesters share one shifter: the exponent-alignment stage (right shifts) and the normalization stage (left shifts). The block accepts one shift job at a time through valid/ready handshakes, with round-robin arbitration between the two stages. It drives the shifter's direction and amount from registered operands and returns a registered result, tagged with its source, through a valid/ready output.

## Interface
- SWR, 26, significand word width in bits (data width of the shifter)
- EW, 5, shift-amount width in bits (number of shifter levels)

- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-low
- a_valid_i  in  1  alignment request valid
- a_data_i  in  SWR  alignment operand
- a_shamt_i  in  EW  alignment right-shift amount
- a_ready_o  out  1  alignment request accepted this cycle
- n_valid_i  in  1  normalization request valid
- n_data_i  in  SWR  normalization operand
- n_shamt_i  in  EW  normalization left-shift amount
- n_ready_o  out  1  normalization request accepted this cycle
- out_valid_o  out  1  result valid
- out_ready_i  in  1  consumer accepts the result
- out_data_o  out  SWR  shifted result
- out_src_o  out  1  result source: 0 = alignment, 1 = normalization
- out_sticky_o  out  1  OR of bits shifted out (see Configuration)

## Operation
- FSM states: IDLE, SHIFT, DONE. Reset state is IDLE.
- IDLE:
  - Ready is combinational: at most one of a_ready_o/n_ready_o is high.
  - If only one valid is high, that channel gets ready.
  - If both valids are high, the channel not served last gets ready.
  - On a handshake (valid & ready), latch the operand, amount, direction (right for A, left for N) and source; update last_served; go to SHIFT.
  - With no valid input, stay in IDLE.
- SHIFT: the shifter evaluates the latched operands. Capture the result into out_data_o, out_src_o and out_sticky_o, set out_valid_o, and go to DONE. Both ready outputs are low.
- DONE: hold all out_* registers stable while out_ready_i is low. When out_ready_i is high, clear out_valid_o and go to IDLE. Both ready outputs are low.
- Shift arithmetic:
  - A: out_data_o = a_data_i >> a_shamt_i, zero-filled.
  - N: out_data_o = n_data_i << n_shamt_i, zero-filled.
  - Shift amounts >= SWR (for example 26 to 31 with the defaults) give out_data_o = 0.
  - Shift amount 0 passes the data through unchanged.
- last_served resets to N, so A wins the first tie after reset.
- Input operands are sampled only at the handshake. Changes to the inputs afterwards have no effect on the job in flight.

## Timing
- Reset values: out_valid_o = 0, out_data_o = 0, out_src_o = 0, out_sticky_o = 0, a_ready_o = 0, n_ready_o = 0 (no valid input is present during reset).
- Latency: a handshake at edge t makes out_valid_o high after edge t+2 (SHIFT at t+1, capture at t+2).
- Throughput: 3 cycles per job when out_ready_i is held high. A new request can be accepted in the cycle after the output handshake.
- Reset asserted in any state: state returns to IDLE immediately and all outputs take their reset values. Any job in flight is dropped.
- A request valid that drops before being granted is not an error; it is simply not served.

## Configuration
- SHIFT_STICKY_EN defined:
  - Right shift: out_sticky_o = OR of the bits of the latched operand shifted out below bit 0.
  - Right shift by >= SWR: out_sticky_o = OR of all operand bits.
  - Left shift: out_sticky_o = 0.
- SHIFT_STICKY_EN undefined: out_sticky_o is tied to 0 and no sticky logic is built. Data and timing behaviour are identical in both builds.

## Test plan
- Reset, then A only: a_data_i = 26'h3FF_F000, shamt = 4 -> out_data_o = 26'h03F_FF00, out_src_o = 0, out_valid_o high 2 cycles after the handshake; sticky = 0.
- N only: n_data_i = 26'h0000_0F1, shamt = 8 -> out_data_o = 26'h000_F100, out_src_o = 1.
- A and N both held valid for 4 jobs with out_ready_i = 1 -> grant order A, N, A, N; one job completes every 3 cycles.
- Backpressure: out_ready_i held low for 5 cycles in DONE -> out_* stable, both ready outputs low, no new grant; completes the cycle out_ready_i rises.
- Boundaries: A, data = 26'h0000_001, shamt = 31 -> out_data_o = 0, sticky = 1 (macro on) / 0 (macro off). Shamt = 0 -> data unchanged.
- Reset asserted in SHIFT -> out_valid_o never rises for that job; after release, the next tie goes to A.

Source files
------------

// File: rtl/shift_arbiter_if.sv
// Handshake bundle between the two shift requesters, the result consumer and shift_arbiter.
// The arbiter connects through the slave modport; the requester/consumer side uses master.
interface shift_arbiter_if #(
  parameter int SWR = 26,
  parameter int EW  = 5
);
  logic           a_valid_i;
  logic [SWR-1:0] a_data_i;
  logic [EW-1:0]  a_shamt_i;
  logic           a_ready_o;
  logic           n_valid_i;
  logic [SWR-1:0] n_data_i;
  logic [EW-1:0]  n_shamt_i;
  logic           n_ready_o;
  logic           out_valid_o;
  logic           out_ready_i;
  logic [SWR-1:0] out_data_o;
  logic           out_src_o;
  logic           out_sticky_o;

  modport slave (
    input  a_valid_i, a_data_i, a_shamt_i,
    output a_ready_o,
    input  n_valid_i, n_data_i, n_shamt_i,
    output n_ready_o,
    output out_valid_o, out_data_o, out_src_o, out_sticky_o,
    input  out_ready_i
  );

  modport master (
    output a_valid_i, a_data_i, a_shamt_i,
    input  a_ready_o,
    output n_valid_i, n_data_i, n_shamt_i,
    input  n_ready_o,
    input  out_valid_o, out_data_o, out_src_o, out_sticky_o,
    output out_ready_i
  );
endinterface

// File: rtl/shift_arbiter.sv
// Round-robin sequencer for the shared barrel shifter (alignment = right, normalization = left).
// Define SHIFT_STICKY_EN to build the sticky (OR of shifted-out bits) output for right shifts.
module shift_arbiter #(
  parameter int SWR = 26,
  parameter int EW  = 5
) (
  input  logic           clk,
  input  logic           rst,
  shift_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t         state;
  state_t         next_state;
  logic           last_n;
  logic [SWR-1:0] op_data;
  logic [EW-1:0]  op_shamt;
  logic           op_left;
  logic           grant_a;
  logic           grant_n;
  logic [SWR-1:0] shift_result;
  logic           sticky_result;
  logic [SWR-1:0] out_data;
  logic           out_valid;
  logic           out_src;
  logic           out_sticky;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // On a tie, the channel that was not served last wins.
  always_comb begin
    next_state = state;
    grant_a    = 1'b0;
    grant_n    = 1'b0;
    case (state)
      IDLE: begin
        grant_a = bus.a_valid_i && (!bus.n_valid_i || last_n);
        grant_n = bus.n_valid_i && (!bus.a_valid_i || !last_n);
        if (grant_a || grant_n) next_state = SHIFT;
      end
      SHIFT:   next_state = DONE;
      DONE:    if (bus.out_ready_i) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_data  <= '0;
      op_shamt <= '0;
      op_left  <= 1'b0;
      last_n   <= 1'b1;
    end else if (grant_a) begin
      op_data  <= bus.a_data_i;
      op_shamt <= bus.a_shamt_i;
      op_left  <= 1'b0;
      last_n   <= 1'b0;
    end else if (grant_n) begin
      op_data  <= bus.n_data_i;
      op_shamt <= bus.n_shamt_i;
      op_left  <= 1'b1;
      last_n   <= 1'b1;
    end
  end

  // Shift amounts at or beyond SWR shift every bit out, leaving zero.
  always_comb begin
    shift_result = op_left ? (op_data << op_shamt) : (op_data >> op_shamt);
  end

`ifdef SHIFT_STICKY_EN
  logic [SWR-1:0] lost_mask;

  always_comb begin
    lost_mask     = ~({SWR{1'b1}} << op_shamt);
    sticky_result = !op_left && (|(op_data & lost_mask));
  end
`else
  always_comb begin
    sticky_result = 1'b0;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_src    <= 1'b0;
      out_sticky <= 1'b0;
    end else if (state == SHIFT) begin
      out_valid  <= 1'b1;
      out_data   <= shift_result;
      out_src    <= op_left;
      out_sticky <= sticky_result;
    end else if (state == DONE && bus.out_ready_i) begin
      out_valid  <= 1'b0;
    end
  end

  assign bus.a_ready_o    = grant_a;
  assign bus.n_ready_o    = grant_n;
  assign bus.out_valid_o  = out_valid;
  assign bus.out_data_o   = out_data;
  assign bus.out_src_o    = out_src;
  assign bus.out_sticky_o = out_sticky;

endmodule

// File: tb/tb_shift_arbiter.sv
// Randomized and directed bench for shift_arbiter against a transaction-level reference model.
// Expected sticky values follow SHIFT_STICKY_EN when the bench is built with it.
module tb_shift_arbiter;
  localparam int SWR = 26;
  localparam int EW  = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cycle = 0;
  int   checks = 0;
  int   passed = 0;

  // Reference model: 0 = idle, 1 = shifting, 2 = result presented
  int             busy = 0;
  logic           a_turn = 1'b1;
  logic [SWR-1:0] job_data;
  logic           job_src;
  logic           job_sticky;
  logic           dut_src[$];
  int             dut_cycle[$];

  shift_arbiter_if #(.SWR(SWR), .EW(EW)) bus();

  shift_arbiter #(.SWR(SWR), .EW(EW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  function automatic longint pow2(input int s);
    longint p = 1;
    for (int i = 0; i < s; i++) p = p * 2;
    return p;
  endfunction

  function automatic logic [SWR-1:0] refData(input logic src, input logic [SWR-1:0] d, input logic [EW-1:0] sh);
    longint v = longint'(d);
    if (int'(sh) >= SWR) return '0;
    if (!src) return SWR'(v / pow2(int'(sh)));
    return SWR'((v * pow2(int'(sh))) % pow2(SWR));
  endfunction

  function automatic logic refSticky(input logic src, input logic [SWR-1:0] d, input logic [EW-1:0] sh);
`ifdef SHIFT_STICKY_EN
    if (src) return 1'b0;
    if (int'(sh) >= SWR) return d != '0;
    return (longint'(d) % pow2(int'(sh))) != 0;
`else
    return 1'b0;
`endif
  endfunction

  // One clock cycle: drive at the falling edge, check, then advance the model.
  task automatic applyStimulus(input logic av, input logic [SWR-1:0] ad, input logic [EW-1:0] ash,
                               input logic nv, input logic [SWR-1:0] nd, input logic [EW-1:0] nsh,
                               input logic ordy);
    logic exp_ar;
    logic exp_nr;
    @(negedge clk);
    bus.a_valid_i   = av;
    bus.a_data_i    = ad;
    bus.a_shamt_i   = ash;
    bus.n_valid_i   = nv;
    bus.n_data_i    = nd;
    bus.n_shamt_i   = nsh;
    bus.out_ready_i = ordy;
    #1;
    exp_ar = (busy == 0) && av && (!nv || a_turn);
    exp_nr = (busy == 0) && nv && (!av || !a_turn);
    checkOutput("a_ready", bus.a_ready_o, exp_ar);
    checkOutput("n_ready", bus.n_ready_o, exp_nr);
    checkOutput("out_valid", bus.out_valid_o, busy == 2);
    if (busy == 2) begin
      checkOutput("out_data", bus.out_data_o, job_data);
      checkOutput("out_src", bus.out_src_o, job_src);
      checkOutput("out_sticky", bus.out_sticky_o, job_sticky);
    end
    if (av && bus.a_ready_o) begin dut_src.push_back(1'b0); dut_cycle.push_back(cycle); end
    if (nv && bus.n_ready_o) begin dut_src.push_back(1'b1); dut_cycle.push_back(cycle); end
    case (busy)
      0: if (exp_ar || exp_nr) begin
        job_src    = exp_nr;
        job_data   = exp_nr ? refData(1'b1, nd, nsh) : refData(1'b0, ad, ash);
        job_sticky = exp_nr ? refSticky(1'b1, nd, nsh) : refSticky(1'b0, ad, ash);
        a_turn     = exp_nr;
        busy       = 1;
      end
      1: busy = 2;
      default: if (ordy) busy = 0;
    endcase
  endtask

  task automatic idleCycle(input logic ordy);
    applyStimulus(1'b0, SWR'($urandom), EW'($urandom), 1'b0, SWR'($urandom), EW'($urandom), ordy);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_valid"}, bus.out_valid_o, 1'b0);
    checkOutput({tag, "_data"}, bus.out_data_o, '0);
    checkOutput({tag, "_src"}, bus.out_src_o, 1'b0);
    checkOutput({tag, "_sticky"}, bus.out_sticky_o, 1'b0);
    checkOutput({tag, "_a_ready"}, bus.a_ready_o, 1'b0);
    checkOutput({tag, "_n_ready"}, bus.n_ready_o, 1'b0);
  endtask

  initial begin
    bus.a_valid_i = 1'b0; bus.a_data_i = '0; bus.a_shamt_i = '0;
    bus.n_valid_i = 1'b0; bus.n_data_i = '0; bus.n_shamt_i = '0;
    bus.out_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    #1 checkResetValues("reset");
    @(negedge clk) rst = 1'b1;

    // A only: grant, shift, then the result is visible two cycles after the handshake
    applyStimulus(1'b1, 26'h3FFF000, 5'd4, 1'b0, '0, '0, 1'b1);
    idleCycle(1'b1);
    idleCycle(1'b1);
    checkOutput("a_only_data", bus.out_data_o, 26'h03FFF00);
    checkOutput("a_only_src", bus.out_src_o, 1'b0);
    checkOutput("a_only_sticky", bus.out_sticky_o, 1'b0);
    idleCycle(1'b1);

    // N only
    applyStimulus(1'b0, '0, '0, 1'b1, 26'h00000F1, 5'd8, 1'b1);
    idleCycle(1'b1);
    idleCycle(1'b1);
    checkOutput("n_only_data", bus.out_data_o, 26'h000F100);
    checkOutput("n_only_src", bus.out_src_o, 1'b1);
    idleCycle(1'b1);

    // Both requesters held valid: alternating grants, one job every 3 cycles
    dut_src.delete(); dut_cycle.delete();
    repeat (12) applyStimulus(1'b1, SWR'($urandom), EW'($urandom), 1'b1, SWR'($urandom), EW'($urandom), 1'b1);
    checkOutput("tie_grant_count", dut_src.size(), 4);
    if (dut_src.size() > 0) checkOutput("tie_src0", dut_src[0], 1'b0);
    for (int i = 1; i < dut_src.size() && i < 4; i++) begin
      checkOutput($sformatf("tie_src%0d", i), dut_src[i], (i % 2) != 0);
      checkOutput($sformatf("tie_gap%0d", i), dut_cycle[i] - dut_cycle[i-1], 3);
    end
    repeat (3) idleCycle(1'b1);

    // Backpressure: result held for 5 cycles while both valids are high
    applyStimulus(1'b1, 26'h1234567, 5'd3, 1'b0, '0, '0, 1'b0);
    idleCycle(1'b0);
    repeat (5) applyStimulus(1'b1, SWR'($urandom), EW'($urandom), 1'b1, SWR'($urandom), EW'($urandom), 1'b0);
    checkOutput("bp_data", bus.out_data_o, 26'h02468AC);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
    idleCycle(1'b1);
    checkOutput("bp_released", bus.out_valid_o, 1'b0);

    // Boundaries: shift past the word, and shift by zero
    applyStimulus(1'b1, 26'h0000001, 5'd31, 1'b0, '0, '0, 1'b1);
    idleCycle(1'b1);
    idleCycle(1'b1);
    checkOutput("big_shamt_data", bus.out_data_o, '0);
`ifdef SHIFT_STICKY_EN
    checkOutput("big_shamt_sticky", bus.out_sticky_o, 1'b1);
`else
    checkOutput("big_shamt_sticky", bus.out_sticky_o, 1'b0);
`endif
    idleCycle(1'b1);
    applyStimulus(1'b0, '0, '0, 1'b1, 26'h2A5A5A5, 5'd0, 1'b1);
    idleCycle(1'b1);
    idleCycle(1'b1);
    checkOutput("zero_shamt_data", bus.out_data_o, 26'h2A5A5A5);
    idleCycle(1'b1);

    // Reset while shifting an A job: job dropped, next tie goes back to A
    applyStimulus(1'b1, 26'h3FFFFFF, 5'd1, 1'b0, '0, '0, 1'b1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    bus.a_valid_i = 1'b0;
    bus.n_valid_i = 1'b0;
    #1 checkResetValues("mid_reset");
    busy = 0;
    a_turn = 1'b1;
    @(negedge clk) rst = 1'b1;
    idleCycle(1'b1);
    checkOutput("mid_reset_valid", bus.out_valid_o, 1'b0);
    applyStimulus(1'b1, 26'h0000F00, 5'd4, 1'b1, 26'h0000001, 5'd1, 1'b1);
    checkOutput("mid_reset_tie_a", bus.a_ready_o, 1'b1);
    repeat (3) idleCycle(1'b1);

    // Randomized traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 2) != 0), SWR'($urandom), EW'($urandom),
                    ($urandom_range(0, 2) != 0), SWR'($urandom), EW'($urandom),
                    ($urandom_range(0, 3) != 0));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
